// File: rtl/col_scan_if.sv
// Column scanner bus: scan enable in, column index / active-low column drivers / frame pulse out.
interface col_scan_if #(
  parameter int NUM_COLS = 5
);
  logic                en;
  logic [2:0]          sel;
  logic [NUM_COLS-1:0] col;
  logic                frame_done;

  modport master (output en, input sel, col, frame_done);
  modport slave  (input en, output sel, col, frame_done);
endinterface

// File: rtl/col_scan.sv
// Prescaled column scanner for the LED matrix; drives the decoder sel and active-low column enables.
// Optional anti-ghosting dead time between columns when SCAN_BLANK_EN is defined.
module col_scan #(
  parameter int DIV          = 50000,
  parameter int NUM_COLS     = 5,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  col_scan_if.slave   bus
);

  localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX  = PW'(DIV - 1);
  localparam logic [2:0]      LAST_COL = 3'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE,
`ifdef SCAN_BLANK_EN
    BLANK,
`endif
    ACTIVE
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [2:0]    nxt_sel;
`ifdef SCAN_BLANK_EN
  localparam logic [7:0] BLANK_MAX = 8'(BLANK_CYCLES - 1);
  logic [7:0]    blank_cnt;
`endif

  function automatic logic [NUM_COLS-1:0] lit_col(input logic [2:0] s);
    return ~(NUM_COLS'(1) << s);
  endfunction

  always_comb begin
    nxt_sel = (bus.sel == LAST_COL) ? '0 : bus.sel + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      presc          <= '0;
      bus.sel        <= '0;
      bus.col        <= '1;
      bus.frame_done <= 1'b0;
`ifdef SCAN_BLANK_EN
      blank_cnt      <= '0;
`endif
    end else begin
      bus.frame_done <= 1'b0;
      if (!bus.en) begin
        // Disable wins over any advance on the same edge, so no frame pulse escapes.
        state   <= IDLE;
        presc   <= '0;
        bus.sel <= '0;
        bus.col <= '1;
      end else begin
        case (state)
          IDLE: begin
            state   <= ACTIVE;
            presc   <= '0;
            bus.sel <= '0;
            bus.col <= lit_col(3'd0);
          end
          ACTIVE: begin
            if (presc == PRE_MAX) begin
              presc          <= '0;
              bus.sel        <= nxt_sel;
              bus.frame_done <= (bus.sel == LAST_COL);
`ifdef SCAN_BLANK_EN
              state          <= BLANK;
              blank_cnt      <= '0;
              bus.col        <= '1;
`else
              bus.col        <= lit_col(nxt_sel);
`endif
            end else begin
              presc <= presc + PW'(1);
            end
          end
`ifdef SCAN_BLANK_EN
          BLANK: begin
            if (blank_cnt == BLANK_MAX) begin
              state   <= ACTIVE;
              presc   <= '0;
              bus.col <= lit_col(bus.sel);
            end else begin
              blank_cnt <= blank_cnt + 8'd1;
            end
          end
`endif
          default: begin
            state   <= IDLE;
            presc   <= '0;
            bus.sel <= '0;
            bus.col <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/col_scan.md
Name: col_scan

Overview:
- Column scanner for the 5-column LED matrix.
- Sits directly upstream of the column pattern decoder.
- Cycles a 3-bit column index (`sel`) through 0..NUM_COLS-1 at a prescaled rate, feeding the decoder's `sel` input.
- Drives the active-low one-hot column enables in lockstep with `sel`, so the decoder's a..g/dp row pattern always matches the lit column.

Parameters:
- DIV, 50000, clock cycles each column stays lit (legal 1..2^20).
- NUM_COLS, 5, number of matrix columns scanned (legal 2..8; `sel` is 3 bits).
- BLANK_CYCLES, 16, dead-time cycles between columns; used only with SCAN_BLANK_EN (legal 1..255).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; low = display off.
- sel  output  3  current column index to the decoder's `sel`.
- col  output  NUM_COLS  column drivers, active-low one-hot; bit i low = column i lit.
- frame_done  output  1  one-cycle pulse when the scan wraps from the last column back to column 0.

Behaviour:
- Reset:
  - Asynchronous: `rst` high immediately forces state IDLE, `sel`=0, `col`=all 1s, `frame_done`=0, prescaler=0.
  - Released state is IDLE.
  - Reset mid-scan aborts the frame; no `frame_done` is produced.
- Prescaler:
  - Width is $clog2(DIV), minimum 1 bit.
  - Counts 0..DIV-1 in ACTIVE; clears to 0 on entering ACTIVE or IDLE.
- State IDLE:
  - Outputs: `col`=all 1s, `sel`=0, `frame_done`=0.
  - `en`=1 at an edge → ACTIVE. Same edge sets `col[0]`=0 and `sel`=0, so the first lit cycle is the one right after `en` is sampled high.
- State ACTIVE:
  - `col` = ~(1 << `sel`); the prescaler increments every cycle.
  - When prescaler = DIV-1 (the advance edge):
    - `sel` becomes `sel`+1, or 0 if `sel` = NUM_COLS-1.
    - `col` follows the new `sel` on the same edge.
    - `frame_done` is high for the one cycle following the wrap to 0.
  - Each column is lit exactly DIV cycles; full frame = NUM_COLS*DIV cycles.
- `en`=0 at any edge, from any state:
  - Next state IDLE, `sel`=0, `col`=all 1s.
  - An advance on the same edge is discarded: no `frame_done`.
- `sel` never exceeds NUM_COLS-1. With NUM_COLS=5 the codes 5..7 never appear at the decoder.
- DIV=1: `sel` advances every cycle; `frame_done` pulses every NUM_COLS cycles.
- `col` never has more than one bit low in any cycle.
- All outputs are registered; there is no combinational path from `en` to the outputs.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined:
  - Adds state BLANK (anti-ghosting dead time).
  - On the advance edge ACTIVE → BLANK: `col`=all 1s, and `sel` updates to the next column on the same edge (the decoder output settles while dark).
  - The blank counter runs BLANK_CYCLES cycles, then BLANK → ACTIVE with `col[sel]`=0 and the prescaler at 0.
  - `frame_done` pulses on the edge entering BLANK for the wrapped column.
  - Column period = DIV + BLANK_CYCLES; frame = NUM_COLS*(DIV+BLANK_CYCLES).
  - `en`=0 during BLANK → IDLE.
- Not defined:
  - No BLANK state and no blank counter logic.
  - Columns switch back-to-back exactly as in ACTIVE above.

Test Plan:
- Reset: `rst`=1 with `en`=1 → `sel`=0, `col`=5'b11111, `frame_done`=0 in the same cycle (asynchronous). Release `rst` → first `col`=5'b11110 appears one edge after `en` is sampled.
- DIV=4, NUM_COLS=5, `en`=1 for 40 cycles:
  - `sel` sequence 0,1,2,3,4,0,... with each value held 4 cycles.
  - `col` = 11110, 11101, 11011, 10111, 01111.
  - `frame_done` high for exactly 1 cycle every 20 cycles, coincident with `sel` returning to 0.
- DIV=1: `sel` changes every cycle; `frame_done` period = 5 cycles; `col` is always one-hot low.
- `en` drop on the advance edge while `sel`=4: next cycle `sel`=0, `col`=11111, `frame_done` stays 0. Re-raise `en` → scan restarts at column 0 with the full DIV dwell.
- Mid-scan reset (`sel`=2, prescaler=2): assert `rst` between edges → outputs reset immediately. After release, the scan resumes from column 0.
- SCAN_BLANK_EN, DIV=4, BLANK_CYCLES=2:
  - Each column is lit 4 cycles, then `col`=11111 for 2 cycles with `sel` already advanced.
  - Frame = 30 cycles; `frame_done` pulses once per frame.
